// File: rtl/spi_slave_core_if.sv
// Host-side bundle of spi_slave_core: TX buffer handshake, received words and status pulses.
interface spi_slave_core_if #(
  parameter int DATA_WIDTH = 32
);
  logic [DATA_WIDTH-1:0] tx_data;
  logic                  tx_valid;
  logic                  tx_ready;
  logic [DATA_WIDTH-1:0] rx_data;
  logic                  rx_valid;
  logic                  tx_underrun;
  logic                  rx_overrun;
  logic                  frame_abort;
  logic                  busy;

  modport master (
    output tx_data, tx_valid,
    input  tx_ready, rx_data, rx_valid, tx_underrun, rx_overrun, frame_abort, busy
  );

  modport slave (
    input  tx_data, tx_valid,
    output tx_ready, rx_data, rx_valid, tx_underrun, rx_overrun, frame_abort, busy
  );
endinterface

// File: rtl/spi_slave_core.sv
// SPI slave with oversampled (synchronized) pins, single-entry TX buffer and per-word RX delivery.
// Supports all four SPI modes, 1..32 bit words, MSB or LSB first.
module spi_slave_core #(
  parameter int SYNC_STAGES = 2,
  parameter int DATA_WIDTH  = 32
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       spi_sclk,
  input  logic       spi_cs_n,
  input  logic       spi_mosi,
  output logic       spi_miso,
  output logic       spi_miso_oe,
  input  logic       cpol,
  input  logic       cpha,
  input  logic       lsb_first,
  input  logic [5:0] word_len,
  spi_slave_core_if.slave host
);
  localparam int PW = $clog2(DATA_WIDTH);

  // state  | meaning
  // IDLE   | deselected, MISO released, waiting for cs_n falling edge
  // ACTIVE | frame selected, shifting words on SCLK edges
  typedef enum logic {IDLE, ACTIVE} state_t;

  state_t                 state;
  logic [SYNC_STAGES-1:0] sclk_sync, cs_sync, mosi_sync;
  logic                   sclk_hist, cs_hist;
  logic                   cpol_q, cpha_q, lsb_q;
  logic [5:0]             last_q;
  logic [5:0]             bit_cnt;
  logic [DATA_WIDTH-1:0]  tx_buf, tx_sh, rx_sh, rx_data_q;
  logic                   buf_full;
  logic                   rx_valid_q, underrun_q, overrun_q, abort_q;
  logic                   miso_q, oe_q, busy_q;

  function automatic logic [5:0] eff_last(input logic [5:0] wl);
    if (wl == 6'd0 || wl > 6'd32) return 6'd31;
    return wl - 6'd1;
  endfunction

  function automatic logic head_bit(input logic [DATA_WIDTH-1:0] v, input logic lsb,
                                    input logic [PW-1:0] pos);
    return lsb ? v[0] : v[pos];
  endfunction

  function automatic logic [DATA_WIDTH-1:0] shift_word(input logic [DATA_WIDTH-1:0] v,
                                                       input logic lsb);
    return lsb ? (v >> 1) : (v << 1);
  endfunction

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      sclk_sync <= '0;
      mosi_sync <= '0;
      // cs_n pipeline clears low so a frame still selected across reset never looks like a new one
      cs_sync   <= '0;
      sclk_hist <= 1'b0;
      cs_hist   <= 1'b0;
    end else begin
      sclk_sync <= {sclk_sync[SYNC_STAGES-2:0], spi_sclk};
      cs_sync   <= {cs_sync[SYNC_STAGES-2:0], spi_cs_n};
      mosi_sync <= {mosi_sync[SYNC_STAGES-2:0], spi_mosi};
      sclk_hist <= sclk_sync[SYNC_STAGES-1];
      cs_hist   <= cs_sync[SYNC_STAGES-1];
    end
  end

  logic                  sclk_q, cs_q, mosi_q;
  logic                  sclk_rise, sclk_fall, cs_fall;
  logic                  sample_edge, shift_edge;
  logic [5:0]            entry_last;
  logic [PW-1:0]         entry_pos, msb_pos;
  logic [DATA_WIDTH-1:0] load_word, rx_next;

  assign sclk_q      = sclk_sync[SYNC_STAGES-1];
  assign cs_q        = cs_sync[SYNC_STAGES-1];
  assign mosi_q      = mosi_sync[SYNC_STAGES-1];
  assign sclk_rise   = sclk_q & ~sclk_hist;
  assign sclk_fall   = ~sclk_q & sclk_hist;
  assign cs_fall     = ~cs_q & cs_hist;
  assign sample_edge = (cpol_q == cpha_q) ? sclk_rise : sclk_fall;
  assign shift_edge  = (cpol_q == cpha_q) ? sclk_fall : sclk_rise;
  assign entry_last  = eff_last(word_len);
  assign entry_pos   = PW'(entry_last);
  assign msb_pos     = PW'(last_q);
  assign load_word   = buf_full ? tx_buf : '0;
  // LSB-first words enter at the top of the active field and drift down to bit 0
  assign rx_next     = lsb_q ? ((rx_sh >> 1) | (DATA_WIDTH'(mosi_q) << msb_pos))
                             : {rx_sh[DATA_WIDTH-2:0], mosi_q};

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state      <= IDLE;
      cpol_q     <= 1'b0;
      cpha_q     <= 1'b0;
      lsb_q      <= 1'b0;
      last_q     <= '0;
      bit_cnt    <= '0;
      tx_buf     <= '0;
      buf_full   <= 1'b0;
      tx_sh      <= '0;
      rx_sh      <= '0;
      rx_data_q  <= '0;
      rx_valid_q <= 1'b0;
      underrun_q <= 1'b0;
      overrun_q  <= 1'b0;
      abort_q    <= 1'b0;
      miso_q     <= 1'b0;
      oe_q       <= 1'b0;
      busy_q     <= 1'b0;
    end else begin
      rx_valid_q <= 1'b0;
      underrun_q <= 1'b0;
      overrun_q  <= 1'b0;
      abort_q    <= 1'b0;
      if (host.tx_valid && !buf_full) begin
        tx_buf   <= host.tx_data;
        buf_full <= 1'b1;
      end
      case (state)
        IDLE: begin
          miso_q  <= 1'b0;
          oe_q    <= 1'b0;
          busy_q  <= 1'b0;
          bit_cnt <= '0;
          if (cs_fall) begin
            state  <= ACTIVE;
            oe_q   <= 1'b1;
            busy_q <= 1'b1;
            cpol_q <= cpol;
            cpha_q <= cpha;
            lsb_q  <= lsb_first;
            last_q <= entry_last;
            rx_sh  <= '0;
            if (buf_full) buf_full <= 1'b0;
            else          underrun_q <= 1'b1;
            if (!cpha) begin
              miso_q <= head_bit(load_word, lsb_first, entry_pos);
              tx_sh  <= shift_word(load_word, lsb_first);
            end else begin
              tx_sh  <= load_word;
            end
          end
        end
        ACTIVE: begin
          if (cs_q) begin
            state   <= IDLE;
            oe_q    <= 1'b0;
            busy_q  <= 1'b0;
            miso_q  <= 1'b0;
            bit_cnt <= '0;
            abort_q <= (bit_cnt != 6'd0);
          end else if (sample_edge) begin
            if (bit_cnt == last_q) begin
              bit_cnt    <= '0;
              rx_data_q  <= rx_next;
              rx_valid_q <= 1'b1;
              // a word landing while the previous pulse is still up left no cycle to capture it
              overrun_q  <= rx_valid_q;
              rx_sh      <= '0;
              tx_sh      <= load_word;
              if (buf_full) buf_full <= 1'b0;
              else          underrun_q <= 1'b1;
            end else begin
              bit_cnt <= bit_cnt + 6'd1;
              rx_sh   <= rx_next;
            end
          end else if (shift_edge) begin
            miso_q <= head_bit(tx_sh, lsb_q, msb_pos);
            tx_sh  <= shift_word(tx_sh, lsb_q);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign spi_miso         = miso_q;
  assign spi_miso_oe      = oe_q;
  assign host.tx_ready    = ~buf_full;
  assign host.rx_data     = rx_data_q;
  assign host.rx_valid    = rx_valid_q;
  assign host.tx_underrun = underrun_q;
  assign host.rx_overrun  = overrun_q;
  assign host.frame_abort = abort_q;
  assign host.busy        = busy_q;
endmodule
